id_ex_latch: RTL and testbench
==============================

# id_ex_latch

ID/EX pipeline register for the five-stage MIPS pipeline, with built-in load-use hazard detection. It captures decoded control, operands, sign-extended immediate and register specifiers from ID. It presents them to EX, where the rt/rd fields feed the 5-bit destination-register select mux. On a load-use hazard it requests a one-cycle stall of PC and IF/ID and inserts a bubble, and it keeps a saturating bubble counter.

## Interface
- DATA_W, 32, operand/PC width
- CNT_W, 16, bubble counter width
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_ctlwb  in  2  {RegWrite, MemtoReg}
- id_ctlm  in  3  {Branch, MemRead, MemWrite}
- id_ctlex  in  4  {RegDst, ALUOp[1:0], ALUSrc}
- id_npc, id_readdat1, id_readdat2, id_signext  in  DATA_W each  PC+4, rs data, rt data, immediate
- id_rs, id_rt, id_rd  in  5 each  register specifiers
- id_uses_rt  in  1  ID instruction reads rt as a source
- flush  in  1  kill the ID instruction (branch taken)
- ex_valid  out  1  registered valid
- ex_ctlwb, ex_ctlm, ex_ctlex  out  2/3/4  registered control
- ex_npc, ex_readdat1, ex_readdat2, ex_signext  out  DATA_W  registered data
- ex_rs, ex_rt, ex_rd  out  5  registered specifiers; ex_rt/ex_rd go to the destination mux
- hazard_stall  out  1  combinational; freeze PC and IF/ID this cycle
- bubble_count  out  CNT_W  saturating count of inserted hazard bubbles

## Operation
- hazard = ex_valid & ex_ctlm[1] (MemRead) & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))) & id_valid.
- hazard_stall = hazard & ~flush_eff. flush_eff is flush when FLUSH is compiled in, and 0 otherwise.
- Each rising edge, evaluated in priority order:
  - **flush_eff = 1:** ex_valid and all ctl fields load 0. Data and specifier fields load the id_* values.
  - **hazard_stall = 1:** a bubble is inserted. ex_valid and ctl fields load 0, and data and specifier fields load the id_* values. bubble_count increments, holding at all-ones.
  - **Otherwise:** all ex_* fields load their id_* counterparts, and ex_valid loads id_valid.
- When id_valid = 0 on a normal load, ctl fields still load the id values. EX gates on ex_valid.
- A bubble has MemRead = 0, so hazard cannot hold for two consecutive cycles. Every stall lasts exactly one cycle.
- Upstream holds the ID instruction during the stall. The next cycle loads it normally.
- There are no other state machines. State is the register bank plus bubble_count.

## Timing
- Reset (rst_n low, asynchronous) clears every registered output to 0, including bubble_count. hazard_stall is then 0 because ex_valid = 0.
- Reset release takes effect at the first rising edge with rst_n high.
- Latency is one cycle from id_* to ex_*.
- hazard_stall is valid in the same cycle as the ID inputs, and is driven only from registered ex_* state and current id_* inputs.
- If flush and hazard occur together, flush wins: there is no stall and no count increment.
- If reset asserts mid-stall, the pipeline returns to the reset state immediately. The pending bubble is lost and not counted.
- bubble_count wraps never; it saturates at 2^CNT_W−1.

## Configuration
- **ID_EX_BRANCH_FLUSH_EN defined:** the flush input behaves as above.
- **Not defined:** flush is ignored and flush_eff = 0. Branches are resolved without squashing, and the port remains for interface stability.

## Test plan
- **Reset:** rst_n=0 mid-cycle with all id_* nonzero → all ex_* and bubble_count read 0 immediately, and hazard_stall=0.
- **Pass-through:** id_valid=1, id_rt=5, id_rd=9, id_readdat1=0x1234_5678, ctlex=4'b1100 → next edge ex_rt=5, ex_rd=9, ex_readdat1=0x1234_5678, ex_ctlex=4'b1100, ex_valid=1.
- **Load-use:** lw with rt=2 in EX, ID instruction has rs=2 → hazard_stall=1 for exactly one cycle. The next edge loads ex_valid=0 and ctl=0, and bubble_count becomes 1. The held instruction loads on the following edge.
- **No false stall:** lw with rt=0 in EX and id_rs=0 → hazard_stall=0. Likewise, lw rt=3 with id_rt=3 and id_uses_rt=0 → no stall.
- **Flush priority:** FLUSH compiled in, hazard condition present, flush=1 → hazard_stall=0, ex_valid=0 next cycle, bubble_count unchanged. Without the macro, the same stimulus stalls.
- **Saturation:** CNT_W=2, force 5 load-use bubbles → bubble_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_latch_if.sv
// ----------------------------------------------------------------------------
// id_ex_latch_if
//   Bundle of signals between the ID stage, the ID/EX latch and the EX stage.
//   Parameters:
//     DATA_W - operand / PC width
//     CNT_W  - width of the bubble counter
//   Modports:
//     master - ID/EX environment: drives id_* and flush, observes ex_*,
//              hazard_stall and bubble_count
//     slave  - the latch itself
// ----------------------------------------------------------------------------
interface id_ex_latch_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    // ID side
    logic              id_valid;
    logic [1:0]        id_ctlwb;     // {RegWrite, MemtoReg}
    logic [2:0]        id_ctlm;      // {Branch, MemRead, MemWrite}
    logic [3:0]        id_ctlex;     // {RegDst, ALUOp[1:0], ALUSrc}
    logic [DATA_W-1:0] id_npc;
    logic [DATA_W-1:0] id_readdat1;
    logic [DATA_W-1:0] id_readdat2;
    logic [DATA_W-1:0] id_signext;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic              id_uses_rt;
    logic              flush;

    // EX side
    logic              ex_valid;
    logic [1:0]        ex_ctlwb;
    logic [2:0]        ex_ctlm;
    logic [3:0]        ex_ctlex;
    logic [DATA_W-1:0] ex_npc;
    logic [DATA_W-1:0] ex_readdat1;
    logic [DATA_W-1:0] ex_readdat2;
    logic [DATA_W-1:0] ex_signext;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_rd;

    // Hazard side
    logic              hazard_stall;
    logic [CNT_W-1:0]  bubble_count;

    modport master (
        output id_valid, id_ctlwb, id_ctlm, id_ctlex,
        output id_npc, id_readdat1, id_readdat2, id_signext,
        output id_rs, id_rt, id_rd, id_uses_rt, flush,
        input  ex_valid, ex_ctlwb, ex_ctlm, ex_ctlex,
        input  ex_npc, ex_readdat1, ex_readdat2, ex_signext,
        input  ex_rs, ex_rt, ex_rd,
        input  hazard_stall, bubble_count
    );

    modport slave (
        input  id_valid, id_ctlwb, id_ctlm, id_ctlex,
        input  id_npc, id_readdat1, id_readdat2, id_signext,
        input  id_rs, id_rt, id_rd, id_uses_rt, flush,
        output ex_valid, ex_ctlwb, ex_ctlm, ex_ctlex,
        output ex_npc, ex_readdat1, ex_readdat2, ex_signext,
        output ex_rs, ex_rt, ex_rd,
        output hazard_stall, bubble_count
    );
endinterface

// File: rtl/id_ex_latch.sv
// ----------------------------------------------------------------------------
// id_ex_latch
//   ID/EX pipeline register of the five-stage MIPS pipeline with load-use
//   hazard detection. A load in EX whose rt is a source of the ID instruction
//   raises hazard_stall for one cycle (PC and IF/ID freeze) and a bubble is
//   written into EX; bubble_count saturates at all-ones.
//
//   Ports:
//     clk   - pipeline clock, rising edge
//     rst_n - asynchronous active-low reset, clears all registered outputs
//     bus   - id_ex_latch_if.slave: id_* inputs, flush, ex_* outputs,
//             hazard_stall (combinational) and bubble_count
//
//   Build option:
//     ID_EX_BRANCH_FLUSH_EN - when defined, flush squashes the ID instruction
//     and overrides a stall; when undefined, flush is ignored.
// ----------------------------------------------------------------------------
module id_ex_latch #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    id_ex_latch_if.slave   bus
);

    logic              valid_q,   valid_d;
    logic [1:0]        ctlwb_q,   ctlwb_d;
    logic [2:0]        ctlm_q,    ctlm_d;
    logic [3:0]        ctlex_q,   ctlex_d;
    logic [DATA_W-1:0] npc_q,     npc_d;
    logic [DATA_W-1:0] rdat1_q,   rdat1_d;
    logic [DATA_W-1:0] rdat2_q,   rdat2_d;
    logic [DATA_W-1:0] sext_q,    sext_d;
    logic [4:0]        rs_q,      rs_d;
    logic [4:0]        rt_q,      rt_d;
    logic [4:0]        rd_q,      rd_d;
    logic [CNT_W-1:0]  bubble_q,  bubble_d;

    logic flush_eff;
    logic hazard;
    logic stall;

`ifdef ID_EX_BRANCH_FLUSH_EN
    assign flush_eff = bus.flush;
`else
    // Port kept for interface stability; branches resolve without squashing.
    logic unused_flush;
    assign unused_flush = bus.flush;
    assign flush_eff    = 1'b0;
`endif

    // Load in EX writing a register the ID instruction reads. r0 never
    // carries a dependency.
    always_comb begin
        hazard = valid_q && ctlm_q[1] && (rt_q != 5'd0) && bus.id_valid &&
                 ((rt_q == bus.id_rs) || (bus.id_uses_rt && (rt_q == bus.id_rt)));
        stall  = hazard && !flush_eff;
    end

    always_comb begin
        // Data and specifiers always follow ID, even into a bubble.
        npc_d   = bus.id_npc;
        rdat1_d = bus.id_readdat1;
        rdat2_d = bus.id_readdat2;
        sext_d  = bus.id_signext;
        rs_d    = bus.id_rs;
        rt_d    = bus.id_rt;
        rd_d    = bus.id_rd;

        valid_d = bus.id_valid;
        ctlwb_d = bus.id_ctlwb;
        ctlm_d  = bus.id_ctlm;
        ctlex_d = bus.id_ctlex;
        if (flush_eff || stall) begin
            valid_d = 1'b0;
            ctlwb_d = '0;
            ctlm_d  = '0;
            ctlex_d = '0;
        end

        bubble_d = bubble_q;
        if (stall && (bubble_q != {CNT_W{1'b1}})) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            ctlwb_q  <= '0;
            ctlm_q   <= '0;
            ctlex_q  <= '0;
            npc_q    <= '0;
            rdat1_q  <= '0;
            rdat2_q  <= '0;
            sext_q   <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            bubble_q <= '0;
        end else begin
            valid_q  <= valid_d;
            ctlwb_q  <= ctlwb_d;
            ctlm_q   <= ctlm_d;
            ctlex_q  <= ctlex_d;
            npc_q    <= npc_d;
            rdat1_q  <= rdat1_d;
            rdat2_q  <= rdat2_d;
            sext_q   <= sext_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            bubble_q <= bubble_d;
        end
    end

    assign bus.ex_valid     = valid_q;
    assign bus.ex_ctlwb     = ctlwb_q;
    assign bus.ex_ctlm      = ctlm_q;
    assign bus.ex_ctlex     = ctlex_q;
    assign bus.ex_npc       = npc_q;
    assign bus.ex_readdat1  = rdat1_q;
    assign bus.ex_readdat2  = rdat2_q;
    assign bus.ex_signext   = sext_q;
    assign bus.ex_rs        = rs_q;
    assign bus.ex_rt        = rt_q;
    assign bus.ex_rd        = rd_q;
    assign bus.hazard_stall = stall;
    assign bus.bubble_count = bubble_q;

endmodule

// File: tb/tb_id_ex_latch.sv
// ----------------------------------------------------------------------------
// tb_id_ex_latch
//   Drives two latches (CNT_W=16 and CNT_W=2) with the same ID stream and
//   checks them against an instruction-level model of the EX stage, plus
//   directed literal expectations.
// ----------------------------------------------------------------------------
module tb_id_ex_latch;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_latch_if #(.DATA_W(32), .CNT_W(16)) bus ();
    id_ex_latch_if #(.DATA_W(32), .CNT_W(2))  sat_bus ();

    id_ex_latch #(.DATA_W(32), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    id_ex_latch #(.DATA_W(32), .CNT_W(2)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sat_bus)
    );

    assign sat_bus.id_valid    = bus.id_valid;
    assign sat_bus.id_ctlwb    = bus.id_ctlwb;
    assign sat_bus.id_ctlm     = bus.id_ctlm;
    assign sat_bus.id_ctlex    = bus.id_ctlex;
    assign sat_bus.id_npc      = bus.id_npc;
    assign sat_bus.id_readdat1 = bus.id_readdat1;
    assign sat_bus.id_readdat2 = bus.id_readdat2;
    assign sat_bus.id_signext  = bus.id_signext;
    assign sat_bus.id_rs       = bus.id_rs;
    assign sat_bus.id_rt       = bus.id_rt;
    assign sat_bus.id_rd       = bus.id_rd;
    assign sat_bus.id_uses_rt  = bus.id_uses_rt;
    assign sat_bus.flush       = bus.flush;

    // One instruction slot as seen by EX.
    typedef struct packed {
        logic        v;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] npc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] se;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } slot_t;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- model ----------------
    slot_t       m_ex      = '0;
    int unsigned m_cnt     = 0;
    int unsigned m_cnt_sat = 0;

    function automatic slot_t id_slot();
        return {bus.id_valid, bus.id_ctlwb, bus.id_ctlm, bus.id_ctlex, bus.id_npc,
                bus.id_readdat1, bus.id_readdat2, bus.id_signext,
                bus.id_rs, bus.id_rt, bus.id_rd};
    endfunction

    function automatic slot_t ex_slot();
        return {bus.ex_valid, bus.ex_ctlwb, bus.ex_ctlm, bus.ex_ctlex, bus.ex_npc,
                bus.ex_readdat1, bus.ex_readdat2, bus.ex_signext,
                bus.ex_rs, bus.ex_rt, bus.ex_rd};
    endfunction

    function automatic logic squash();
`ifdef ID_EX_BRANCH_FLUSH_EN
        return bus.flush;
`else
        return 1'b0;
`endif
    endfunction

    // ID needs a register that the load now in EX has not yet produced.
    function automatic logic must_wait();
        logic       load_in_ex;
        logic [4:0] dst;
        logic       reads_dst;
        load_in_ex = m_ex.v && m_ex.m[1];
        dst        = m_ex.rt;
        reads_dst  = (bus.id_rs == dst) || (bus.id_uses_rt && bus.id_rt == dst);
        return load_in_ex && dst != 0 && bus.id_valid && reads_dst && !squash();
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex      = '0;
            m_cnt     = 0;
            m_cnt_sat = 0;
        end else begin
            slot_t nxt;
            nxt = id_slot();
            if (squash() || must_wait()) begin
                nxt.v  = 1'b0;
                nxt.wb = '0;
                nxt.m  = '0;
                nxt.ex = '0;
            end
            if (must_wait()) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt_sat < 3) m_cnt_sat++;
            end
            m_ex = nxt;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("ex_slot", 160'(ex_slot()), 160'(m_ex));
        check("hazard_stall", 160'(bus.hazard_stall), 160'(must_wait()));
        check("bubble_count", 160'(bus.bubble_count), 160'(m_cnt));
        check("bubble_count_sat", 160'(sat_bus.bubble_count), 160'(m_cnt_sat));
    end

    // ---------------- stimulus ----------------
    task automatic set_id(input logic v, input logic [1:0] wb, input logic [2:0] m,
                          input logic [3:0] ex, input logic [31:0] r1,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic uses_rt, input logic fl);
        bus.id_valid    = v;
        bus.id_ctlwb    = wb;
        bus.id_ctlm     = m;
        bus.id_ctlex    = ex;
        bus.id_npc      = r1 ^ 32'h0000_0104;
        bus.id_readdat1 = r1;
        bus.id_readdat2 = ~r1;
        bus.id_signext  = {27'd0, rd};
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_rd       = rd;
        bus.id_uses_rt  = uses_rt;
        bus.flush       = fl;
    endtask

    // lw rt, imm(rs)
    task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt);
        set_id(1'b1, 2'b11, 3'b010, 4'b0011, 32'h0000_1000, rs, rt, 5'd0, 1'b0, 1'b0);
    endtask

    // R-type rd = rs op rt
    task automatic set_alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic fl);
        set_id(1'b1, 2'b10, 3'b000, 4'b1100, 32'h0000_2000, rs, rt, rd, 1'b1, fl);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int unsigned sat_exp[5] = '{1, 2, 3, 3, 3};

    initial begin
        rst_n = 1'b1;
        set_id(1'b1, 2'b11, 3'b111, 4'b1111, 32'hDEAD_BEEF, 5'd7, 5'd8, 5'd9, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_ex_slot", 160'(ex_slot()), 160'd0);
        check("reset_bubble_count", 160'(bus.bubble_count), 160'd0);
        check("reset_hazard_stall", 160'(bus.hazard_stall), 160'd0);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;

        // Pass-through
        set_id(1'b1, 2'b10, 3'b000, 4'b1100, 32'h1234_5678, 5'd1, 5'd5, 5'd9, 1'b1, 1'b0);
        step();
        check("pass_ex_rt", 160'(bus.ex_rt), 160'd5);
        check("pass_ex_rd", 160'(bus.ex_rd), 160'd9);
        check("pass_ex_readdat1", 160'(bus.ex_readdat1), 160'h1234_5678);
        check("pass_ex_ctlex", 160'(bus.ex_ctlex), 160'b1100);
        check("pass_ex_valid", 160'(bus.ex_valid), 160'd1);

        // Load-use: lw r2 then consumer of r2
        set_lw(5'd4, 5'd2);
        step();
        set_alu(5'd2, 5'd6, 5'd7, 1'b0);
        #1 check("lu_stall", 160'(bus.hazard_stall), 160'd1);
        step();
        check("lu_bubble_valid", 160'(bus.ex_valid), 160'd0);
        check("lu_bubble_ctlm", 160'(bus.ex_ctlm), 160'd0);
        check("lu_count", 160'(bus.bubble_count), 160'd1);
        check("lu_stall_one_cycle", 160'(bus.hazard_stall), 160'd0);
        step();
        check("lu_held_valid", 160'(bus.ex_valid), 160'd1);
        check("lu_held_rs", 160'(bus.ex_rs), 160'd2);

        // No false stall: r0 destination, and rt not used as source
        set_lw(5'd1, 5'd0);
        step();
        set_alu(5'd0, 5'd0, 5'd4, 1'b0);
        #1 check("r0_no_stall", 160'(bus.hazard_stall), 160'd0);
        step();
        set_lw(5'd1, 5'd3);
        step();
        set_id(1'b1, 2'b11, 3'b010, 4'b0011, 32'h0000_3000, 5'd4, 5'd3, 5'd0, 1'b0, 1'b0);
        #1 check("rt_unused_no_stall", 160'(bus.hazard_stall), 160'd0);
        step();

        // Flush against a pending hazard
        set_lw(5'd4, 5'd2);
        step();
        set_alu(5'd2, 5'd6, 5'd7, 1'b1);
`ifdef ID_EX_BRANCH_FLUSH_EN
        #1 check("flush_stall", 160'(bus.hazard_stall), 160'd0);
        step();
        check("flush_count", 160'(bus.bubble_count), 160'd1);
`else
        #1 check("noflush_stall", 160'(bus.hazard_stall), 160'd1);
        step();
        check("noflush_count", 160'(bus.bubble_count), 160'd2);
`endif
        check("flush_ex_valid", 160'(bus.ex_valid), 160'd0);
        set_id(1'b0, 2'b00, 3'b000, 4'b0000, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();

        // Reset arriving mid-stall
        set_lw(5'd4, 5'd2);
        step();
        set_alu(5'd2, 5'd6, 5'd7, 1'b0);
        #1 check("pre_reset_stall", 160'(bus.hazard_stall), 160'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_ex_slot", 160'(ex_slot()), 160'd0);
        check("midreset_count", 160'(bus.bubble_count), 160'd0);
        check("midreset_stall", 160'(bus.hazard_stall), 160'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation: lw r2,0(r2) held in ID stalls on every other edge
        set_lw(5'd2, 5'd2);
        for (int i = 0; i < 5; i++) begin
            step();
            check("sat_stall", 160'(bus.hazard_stall), 160'd1);
            step();
            check("sat_count", 160'(sat_bus.bubble_count), 160'(sat_exp[i]));
            check("wide_count", 160'(bus.bubble_count), 160'(i + 1));
        end

        set_id(1'b0, 2'b00, 3'b000, 4'b0000, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        step();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
